// File: rtl/ex_mem_redirect_pkg.sv
// Shared definitions for the EX/MEM branch-resolution and fetch-redirect stage.
package ex_mem_redirect_pkg;

   localparam int DEFAULT_WIDTH = 32;

   // Branch immediates are word offsets, so they become byte offsets after this shift.
   localparam int BRANCH_SHIFT = 2;

   // Three bits hold a squash length of up to 7 cycles.
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      SQUASH   = 2'd2
   } redirect_state_t;

endpackage

// File: rtl/ex_mem_redirect_branch_target_calc.sv
// Branch target adder and operand equality compare. This block is purely
// combinational so that a later BNE/J unit can reuse it.
module branch_target_calc
   import ex_mem_redirect_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] i_npc,
   input  logic [WIDTH-1:0] i_imm,
   input  logic [WIDTH-1:0] i_rs,
   input  logic [WIDTH-1:0] i_rt,
   output logic [WIDTH-1:0] o_target,
   output logic             o_zero
);

   logic [WIDTH-1:0] w_offset;

   // The top bits of the immediate are shifted out, and the add wraps modulo 2^WIDTH.
   always_comb begin
      w_offset = i_imm << BRANCH_SHIFT;
      o_target = i_npc + w_offset;
      o_zero   = (i_rs == i_rt);
   end

endmodule

// File: rtl/ex_mem_redirect.sv
// EX/MEM branch resolution. This stage latches the branch outcome and target,
// drives a one-cycle PC-select pulse to fetch, and then flushes the wrong-path
// instructions in IF/ID and ID/EX.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | accepting instructions; a taken BEQ moves to REDIRECT
// REDIRECT | pcsrc and flush are high; the ID/EX occupant is wrong-path
// SQUASH   | flush and busy_squash are high; the counter runs down to 0
module ex_mem_redirect
   import ex_mem_redirect_pkg::*;
#(
   parameter int WIDTH        = DEFAULT_WIDTH,
   // Total number of flush cycles, counting REDIRECT. The legal range is 1 to 7.
   parameter int SQUASH_DEPTH = 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             in_valid,
   input  logic             in_branch,
   input  logic [WIDTH-1:0] in_npc,
   input  logic [WIDTH-1:0] in_imm,
   input  logic [WIDTH-1:0] in_rs,
   input  logic [WIDTH-1:0] in_rt,
   output logic             ex_mem_valid,
   output logic             ex_mem_zero,
   output logic             ex_mem_pcsrc,
   output logic [WIDTH-1:0] ex_mem_target,
   output logic             flush,
   output logic             busy_squash
);

   localparam logic [CNT_W-1:0] SQ_LOAD = CNT_W'(SQUASH_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   redirect_state_t  r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_valid;
   logic             r_zero;
   logic [WIDTH-1:0] r_target;
   logic             r_pcsrc;
   logic             r_flush;
   logic             r_busy;

   logic [WIDTH-1:0] w_target;
   logic             w_zero;
   logic             w_accept;
   logic             w_taken;

   branch_target_calc #(
      .WIDTH (WIDTH)
   ) u_calc (
      .i_npc    (in_npc),
      .i_imm    (in_imm),
      .i_rs     (in_rs),
      .i_rt     (in_rt),
      .o_target (w_target),
      .o_zero   (w_zero)
   );

   // Only IDLE accepts instructions. Whatever sits in ID/EX during REDIRECT or
   // SQUASH is younger than the taken branch and is therefore wrong-path.
   always_comb begin
      w_accept = in_valid & ~r_busy & (r_state != REDIRECT);
      w_taken  = w_accept & in_branch & w_zero;
   end

   // The EX/MEM latch loads on every edge because there is no stall path.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_valid  <= 1'b0;
         r_zero   <= 1'b0;
         r_target <= '0;
      end else begin
         r_valid  <= w_accept;
         r_zero   <= w_zero;
         r_target <= w_target;
      end
   end

   // Redirect/squash FSM. Its outputs are registered next to the state, so none of them glitch.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pcsrc <= 1'b0;
         r_flush <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_taken) begin
                  r_state <= REDIRECT;
                  r_cnt   <= SQ_LOAD;
                  r_pcsrc <= 1'b1;
                  r_flush <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            REDIRECT: begin
               r_pcsrc <= 1'b0;
               if (SQUASH_DEPTH > 1) begin
                  r_state <= SQUASH;
                  r_cnt   <= r_cnt - CNT_ONE;
                  r_flush <= 1'b1;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_flush <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end
            SQUASH: begin
               if (r_cnt == '0) begin
                  r_state <= IDLE;
                  r_flush <= 1'b0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_pcsrc <= 1'b0;
               r_flush <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ex_mem_valid  = r_valid;
   assign ex_mem_zero   = r_zero;
   assign ex_mem_target = r_target;
   assign ex_mem_pcsrc  = r_pcsrc;
   assign flush         = r_flush;
   assign busy_squash   = r_busy;

endmodule

// File: tb/tb_ex_mem_redirect.sv
// Testbench for ex_mem_redirect: a table of single-instruction vectors plus hand-written
// sequences for back-to-back branches, async reset mid-squash and a depth-1 build.
module tb_ex_mem_redirect;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_branch = 1'b0;
   logic [31:0] in_npc = '0;
   logic [31:0] in_imm = '0;
   logic [31:0] in_rs = '0;
   logic [31:0] in_rt = '0;

   logic        o0_valid, o0_zero, o0_pcsrc, o0_flush, o0_busy;
   logic [31:0] o0_target;
   logic        o1_valid, o1_zero, o1_pcsrc, o1_flush, o1_busy;
   logic [31:0] o1_target;

   int n_total = 0;
   int n_pass  = 0;
   int busy1_seen = 0;

   ex_mem_redirect #(.WIDTH(32), .SQUASH_DEPTH(2)) dut0 (
      .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_branch(in_branch),
      .in_npc(in_npc), .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt),
      .ex_mem_valid(o0_valid), .ex_mem_zero(o0_zero), .ex_mem_pcsrc(o0_pcsrc),
      .ex_mem_target(o0_target), .flush(o0_flush), .busy_squash(o0_busy)
   );

   ex_mem_redirect #(.WIDTH(32), .SQUASH_DEPTH(1)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_branch(in_branch),
      .in_npc(in_npc), .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt),
      .ex_mem_valid(o1_valid), .ex_mem_zero(o1_zero), .ex_mem_pcsrc(o1_pcsrc),
      .ex_mem_target(o1_target), .flush(o1_flush), .busy_squash(o1_busy)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (o1_busy === 1'b1) busy1_seen++;

   typedef struct {
      string       nm;
      logic        v, z, pc, fl, bz;
      logic [31:0] t;
   } exp_t;

   typedef struct {
      logic        v, b;
      logic [31:0] npc, imm, rs, rt;
      logic        ev, ez, epc;
      logic [31:0] et;
   } vec_t;

   exp_t q[$];
   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic exp_t mk(input string nm, input logic v, input logic z,
                               input logic [31:0] t, input logic pc, input logic fl,
                               input logic bz);
      exp_t e;
      e.nm = nm; e.v = v; e.z = z; e.t = t; e.pc = pc; e.fl = fl; e.bz = bz;
      return e;
   endfunction

   // Drives one cycle of inputs and queues what the stage must show after the
   // next edge. It then pops that entry and compares it against dut0.
   task automatic cycle(input logic v, input logic b, input logic [31:0] npc,
                        input logic [31:0] imm, input logic [31:0] rs,
                        input logic [31:0] rt, input exp_t e);
      exp_t got;
      in_valid = v; in_branch = b; in_npc = npc; in_imm = imm; in_rs = rs; in_rt = rt;
      q.push_back(e);
      @(posedge CLK); #1;
      got = q.pop_front();
      chk({got.nm, ".valid"},  {31'b0, o0_valid},  {31'b0, got.v});
      chk({got.nm, ".zero"},   {31'b0, o0_zero},   {31'b0, got.z});
      chk({got.nm, ".target"}, o0_target,          got.t);
      chk({got.nm, ".pcsrc"},  {31'b0, o0_pcsrc},  {31'b0, got.pc});
      chk({got.nm, ".flush"},  {31'b0, o0_flush},  {31'b0, got.fl});
      chk({got.nm, ".busy"},   {31'b0, o0_busy},   {31'b0, got.bz});
   endtask

   task automatic idle(input exp_t e);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, e);
   endtask

   initial begin
      //            v     b     npc           imm           rs            rt            ev    ez    epc   et
      vecs[0] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_0003, 32'd5,        32'd5,        1'b1, 1'b1, 1'b1, 32'h0000_004C};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_0003, 32'd5,        32'd6,        1'b1, 1'b0, 1'b0, 32'h0000_004C};
      vecs[2] = '{1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFF8, 32'd7,        32'd7,        1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0};
      vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0001, 32'd1,        32'd1,        1'b1, 1'b1, 1'b0, 32'h0000_0000};
      vecs[4] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0000_0010, 32'd3,        32'd3,        1'b0, 1'b1, 1'b0, 32'h0000_0140};
      vecs[5] = '{1'b1, 1'b1, 32'h0000_0000, 32'h4000_0001, 32'd0,        32'd0,        1'b1, 1'b1, 1'b1, 32'h0000_0004};
      vecs[6] = '{1'b1, 1'b1, 32'h0000_1000, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b1, 1'b0, 1'b0, 32'h0000_1000};

      // Asynchronous reset with no clock edge in between.
      #2 RST_N = 1'b0;
      #1;
      chk("rst.valid",  {31'b0, o0_valid}, 32'h0);
      chk("rst.pcsrc",  {31'b0, o0_pcsrc}, 32'h0);
      chk("rst.flush",  {31'b0, o0_flush}, 32'h0);
      chk("rst.busy",   {31'b0, o0_busy},  32'h0);
      chk("rst.target", o0_target,         32'h0);
      @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK); #1;

      // Table vectors. Each one starts in IDLE and is followed by two idle cycles.
      // A taken branch gives REDIRECT, then one SQUASH cycle, then IDLE.
      for (int i = 0; i < 7; i++) begin
         cycle(vecs[i].v, vecs[i].b, vecs[i].npc, vecs[i].imm, vecs[i].rs, vecs[i].rt,
               mk($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ez, vecs[i].et,
                  vecs[i].epc, vecs[i].epc, 1'b0));
         idle(mk($sformatf("vec%0d+1", i), 1'b0, 1'b1, 32'h0, 1'b0, vecs[i].epc, vecs[i].epc));
         idle(mk($sformatf("vec%0d+2", i), 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0));
      end

      // Three taken branches back to back. Only the first one redirects. The
      // branch presented in the first IDLE cycle after that redirects again.
      cycle(1'b1, 1'b1, 32'h200, 32'h1, 32'd9, 32'd9, mk("b2b.e1", 1'b1, 1'b1, 32'h204, 1'b1, 1'b1, 1'b0));
      cycle(1'b1, 1'b1, 32'h200, 32'h1, 32'd9, 32'd9, mk("b2b.e2", 1'b0, 1'b1, 32'h204, 1'b0, 1'b1, 1'b1));
      cycle(1'b1, 1'b1, 32'h200, 32'h1, 32'd9, 32'd9, mk("b2b.e3", 1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 1'b0));
      cycle(1'b1, 1'b1, 32'h300, 32'h2, 32'd4, 32'd4, mk("b2b.e4", 1'b1, 1'b1, 32'h308, 1'b1, 1'b1, 1'b0));
      idle(mk("b2b.e5", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1));
      idle(mk("b2b.e6", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0));

      // Depth-1 build: REDIRECT goes straight back to IDLE and flush lasts one cycle.
      cycle(1'b1, 1'b1, 32'h80, 32'h4, 32'd2, 32'd2, mk("d1.e1", 1'b1, 1'b1, 32'h90, 1'b1, 1'b1, 1'b0));
      chk("d1.e1.pcsrc", {31'b0, o1_pcsrc}, 32'h1);
      chk("d1.e1.flush", {31'b0, o1_flush}, 32'h1);
      chk("d1.e1.busy",  {31'b0, o1_busy},  32'h0);
      chk("d1.e1.target", o1_target,        32'h90);
      idle(mk("d1.e2", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1));
      chk("d1.e2.pcsrc", {31'b0, o1_pcsrc}, 32'h0);
      chk("d1.e2.flush", {31'b0, o1_flush}, 32'h0);
      chk("d1.e2.busy",  {31'b0, o1_busy},  32'h0);
      idle(mk("d1.e3", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0));

      // Pull reset in the middle of a cycle while SQUASH is active.
      cycle(1'b1, 1'b1, 32'h40, 32'h3, 32'd5, 32'd5, mk("rs.e1", 1'b1, 1'b1, 32'h4C, 1'b1, 1'b1, 1'b0));
      cycle(1'b0, 1'b0, 32'h500, 32'h0, 32'd0, 32'd0, mk("rs.e2", 1'b0, 1'b1, 32'h500, 1'b0, 1'b1, 1'b1));
      #2 RST_N = 1'b0;
      #1;
      chk("rs.async.valid",  {31'b0, o0_valid}, 32'h0);
      chk("rs.async.zero",   {31'b0, o0_zero},  32'h0);
      chk("rs.async.pcsrc",  {31'b0, o0_pcsrc}, 32'h0);
      chk("rs.async.flush",  {31'b0, o0_flush}, 32'h0);
      chk("rs.async.busy",   {31'b0, o0_busy},  32'h0);
      chk("rs.async.target", o0_target,         32'h0);
      chk("rs.async.d1flush", {31'b0, o1_flush}, 32'h0);
      @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      idle(mk("rs.after", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0));
      idle(mk("rs.after2", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0));
      cycle(1'b1, 1'b1, 32'h600, 32'h1, 32'd8, 32'd8, mk("rs.taken", 1'b1, 1'b1, 32'h604, 1'b1, 1'b1, 1'b0));
      idle(mk("rs.taken+1", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1));
      idle(mk("rs.taken+2", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0));

      chk("d1.busy_never", busy1_seen, 32'h0);
      chk("sb.empty", q.size(), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
